slc3_mem_if: RTL and testbench

SLC3_MEM_IF -- requirements
Module: slc3_mem_if

---
 rtl/slc3_pkg.sv | 25 ++
 rtl/slc3_mem2io.sv | 36 +++
 rtl/slc3_mem_if.sv | 120 ++++++++++++
 tb/tb_slc3_mem_if.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// slc3_pkg -- definitions shared by the SLC-3 memory interface.
//   IO_ADDR        : address of the memory-mapped switch/display register
//   access_state_t : states of the SRAM access FSM
//   is_read/is_write : helpers that classify an access state
package slc3_pkg;

  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR1,
    WR2
  } access_state_t;

  function automatic logic is_read(input access_state_t s);
    return (s == RD1) || (s == RD2);
  endfunction

  function automatic logic is_write(input access_state_t s);
    return (s == WR1) || (s == WR2);
  endfunction

endpackage

// File: rtl/slc3_mem2io.sv
// slc3_mem2io -- address decode and read-data selection.
//   mar, mar_next      : current and next-cycle address register values
//   state_next         : access state the FSM enters at the coming edge
//   sw, sram_d_in      : switch inputs and SRAM read data
//   is_io              : current MAR targets the I/O register
//   rd_data            : memory read data (switches for I/O, else SRAM)
//   oe_n_next, we_n_next : SRAM strobe values for the coming cycle
module slc3_mem2io
  import slc3_pkg::*;
(
  input  logic [15:0]   mar,
  input  logic [15:0]   mar_next,
  input  access_state_t state_next,
  input  logic [15:0]   sw,
  input  logic [15:0]   sram_d_in,
  output logic          is_io,
  output logic [15:0]   rd_data,
  output logic          oe_n_next,
  output logic          we_n_next
);

  logic io_next;

  assign is_io   = (mar == IO_ADDR);
  assign io_next = (mar_next == IO_ADDR);

  // SRAM data only reaches the rest of the design through this mux into MDR.
  assign rd_data = is_io ? sw : sram_d_in;

  // Strobes are decoded one cycle ahead and registered in the top, so each
  // pin equals the decode of the registered state and MAR with no glitches.
  // An I/O access never touches the SRAM.
  assign oe_n_next = !(is_read(state_next)  && !io_next);
  assign we_n_next = !(is_write(state_next) && !io_next);

endmodule

// File: rtl/slc3_mem_if.sv
// slc3_mem_if -- SLC-3 CPU to SRAM memory interface.
//   Clk, Reset        : clock and synchronous active-high reset
//   LD_MAR, LD_MDR    : register load enables
//   Mem_OE, Mem_WE    : read / write requests from the control unit
//   Bus_in, SW        : CPU data bus and board switches
//   MAR, MDR          : address and data registers
//   SRAM_*            : SRAM address, data and active-low strobes
//   HEX_DATA          : display register written at address IO_ADDR
//   ACC_ERR           : sticky flag for protocol misuse
//
// A read or write request held for N consecutive cycles is an access whose
// first cycle is RD1/WR1 and whose later cycles are RD2/WR2; the state
// register holds the phase of the previous cycle, so the SRAM strobes (a
// decode of that register) follow the request by one cycle.
module slc3_mem_if
  import slc3_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] Bus_in,
  input  logic [15:0] SW,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [19:0] SRAM_ADDR,
  input  logic [15:0] SRAM_D_in,
  output logic [15:0] SRAM_D_out,
  output logic        SRAM_D_oe,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [15:0] HEX_DATA,
  output logic        ACC_ERR
);

  access_state_t state, state_next;
  logic [15:0]   mar_next, mdr_next, rd_data;
  logic          rd_req, wr_req, conflict;
  logic          is_io, oe_n_next, we_n_next;
  logic          hex_load, early_read, err_set;

  // Both strobes together is not a request at all: neither rd_req nor
  // wr_req is true, so the FSM falls back to IDLE.
  assign rd_req   = Mem_OE & ~Mem_WE;
  assign wr_req   = Mem_WE & ~Mem_OE;
  assign conflict = Mem_OE & Mem_WE;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = IDLE;
    unique case (state)
      IDLE:     if (rd_req) state_next = RD1;
                else if (wr_req) state_next = WR1;
      RD1, RD2: if (rd_req) state_next = RD2;
      WR1, WR2: if (wr_req) state_next = WR2;
      default:  state_next = IDLE;
    endcase
  end

  assign mar_next = LD_MAR ? Bus_in : MAR;
  assign mdr_next = LD_MDR ? (Mem_OE ? rd_data : Bus_in) : MDR;

  // The display loads once, as the access moves from WR1 into WR2; a write
  // that lingers in WR2 does not reload it.
  assign hex_load = (state == WR1) && (state_next == WR2) && is_io;

  // Memory data is only valid from the second request cycle; capturing it in
  // the first cycle (the one entering RD1) still loads but is flagged.
  assign early_read = LD_MDR & Mem_OE & (state_next == RD1);
  assign err_set    = conflict | early_read | (LD_MAR & (state != IDLE));

  slc3_mem2io u_mem2io (
    .mar        (MAR),
    .mar_next   (mar_next),
    .state_next (state_next),
    .sw         (SW),
    .sram_d_in  (SRAM_D_in),
    .is_io      (is_io),
    .rd_data    (rd_data),
    .oe_n_next  (oe_n_next),
    .we_n_next  (we_n_next)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      MAR       <= '0;
      MDR       <= '0;
      HEX_DATA  <= '0;
      ACC_ERR   <= 1'b0;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_D_oe <= 1'b0;
    end else begin
      state     <= state_next;
      MAR       <= mar_next;
      MDR       <= mdr_next;
      ACC_ERR   <= ACC_ERR | err_set;
      SRAM_OE_N <= oe_n_next;
      SRAM_WE_N <= we_n_next;
      SRAM_D_oe <= ~we_n_next;
      if (hex_load) HEX_DATA <= MDR;
    end
  end

  assign SRAM_ADDR  = {4'h0, MAR};
  assign SRAM_D_out = MDR;
  assign SRAM_CE_N  = 1'b0;
  assign SRAM_UB_N  = 1'b0;
  assign SRAM_LB_N  = 1'b0;

endmodule

// File: tb/tb_slc3_mem_if.sv
// tb_slc3_mem_if -- directed scenarios plus randomized transactions checked
// against a transaction-level model of the memory interface.
module tb_slc3_mem_if;

  localparam logic [15:0] IO = 16'hFFFF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0, LD_MAR = 1'b0, LD_MDR = 1'b0;
  logic        Mem_OE = 1'b0, Mem_WE = 1'b0;
  logic [15:0] Bus_in = '0, SW = '0, SRAM_D_in = '0;
  logic [15:0] MAR, MDR, SRAM_D_out, HEX_DATA;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_D_oe, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  logic        ACC_ERR;

  int errors = 0;
  int checks = 0;

  // transaction-level model state
  logic [15:0] m_mar, m_mdr, m_hex;
  logic        m_err;

  slc3_mem_if dut (
    .Clk(Clk), .Reset(Reset), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Bus_in(Bus_in), .SW(SW),
    .MAR(MAR), .MDR(MDR), .SRAM_ADDR(SRAM_ADDR), .SRAM_D_in(SRAM_D_in),
    .SRAM_D_out(SRAM_D_out), .SRAM_D_oe(SRAM_D_oe), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .HEX_DATA(HEX_DATA), .ACC_ERR(ACC_ERR)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_idle();
    LD_MAR = 1'b0; LD_MDR = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    m_mar = '0; m_mdr = '0; m_hex = '0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    // Loads and strobes active during reset must be ignored.
    Reset = 1'b1; LD_MAR = 1'b1; LD_MDR = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
    Bus_in = 16'hDEAD; SW = 16'hCAFE; SRAM_D_in = 16'hF00D;
    step();
    step();
    checks++; if (MAR !== 16'h0) begin errors++; $display("FAIL reset_mar: got %h want 0000", MAR); end
    checks++; if (MDR !== 16'h0) begin errors++; $display("FAIL reset_mdr: got %h want 0000", MDR); end
    checks++; if (HEX_DATA !== 16'h0) begin errors++; $display("FAIL reset_hex: got %h want 0000", HEX_DATA); end
    checks++; if (ACC_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ACC_ERR); end
    checks++; if (SRAM_OE_N !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_D_oe !== 1'b0)
      begin errors++; $display("FAIL reset_strobes: got oe_n=%b we_n=%b d_oe=%b want 1 1 0", SRAM_OE_N, SRAM_WE_N, SRAM_D_oe); end
    checks++; if (SRAM_CE_N !== 1'b0 || SRAM_UB_N !== 1'b0 || SRAM_LB_N !== 1'b0)
      begin errors++; $display("FAIL reset_const: got ce=%b ub=%b lb=%b want 0 0 0", SRAM_CE_N, SRAM_UB_N, SRAM_LB_N); end
    checks++; if (SRAM_ADDR !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000", SRAM_ADDR); end
    do_reset();
  endtask

  task automatic test_read();
    do_reset();
    LD_MAR = 1'b1; Bus_in = 16'h0010;
    step();
    LD_MAR = 1'b0; SRAM_D_in = 16'h1234; Mem_OE = 1'b1;
    checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL read_oe_c1: got %b want 1", SRAM_OE_N); end
    step();
    LD_MDR = 1'b1;
    checks++; if (SRAM_OE_N !== 1'b0) begin errors++; $display("FAIL read_oe_c2: got %b want 0", SRAM_OE_N); end
    step();
    set_idle();
    checks++; if (SRAM_OE_N !== 1'b0) begin errors++; $display("FAIL read_oe_c3: got %b want 0", SRAM_OE_N); end
    checks++; if (MDR !== 16'h1234) begin errors++; $display("FAIL read_mdr: got %h want 1234", MDR); end
    step();
    checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL read_oe_end: got %b want 1", SRAM_OE_N); end
    checks++; if (MAR !== 16'h0010) begin errors++; $display("FAIL read_mar: got %h want 0010", MAR); end
    checks++; if (SRAM_ADDR !== 20'h00010) begin errors++; $display("FAIL read_addr: got %h want 00010", SRAM_ADDR); end
    checks++; if (ACC_ERR !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", ACC_ERR); end
  endtask

  task automatic test_io_read();
    do_reset();
    LD_MAR = 1'b1; Bus_in = IO;
    step();
    LD_MAR = 1'b0; SW = 16'hBEEF; SRAM_D_in = 16'h1111; Mem_OE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) LD_MDR = 1'b1;
      if (i == 2) set_idle();
      checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL io_read_oe_c%0d: got %b want 1", i, SRAM_OE_N); end
      step();
    end
    checks++; if (MDR !== 16'hBEEF) begin errors++; $display("FAIL io_read_mdr: got %h want beef", MDR); end
    checks++; if (ACC_ERR !== 1'b0) begin errors++; $display("FAIL io_read_err: got %b want 0", ACC_ERR); end
  endtask

  task automatic test_io_write();
    logic exp_low [4];
    int   low_cycles;
    exp_low = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    LD_MAR = 1'b1; Bus_in = IO;
    step();
    LD_MAR = 1'b0; LD_MDR = 1'b1; Bus_in = 16'h00A5;
    step();
    LD_MDR = 1'b0;
    checks++; if (MDR !== 16'h00A5) begin errors++; $display("FAIL io_wr_mdr: got %h want 00a5", MDR); end
    Mem_WE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) set_idle();
      checks++; if (SRAM_WE_N !== 1'b1 || SRAM_D_oe !== 1'b0)
        begin errors++; $display("FAIL io_wr_strobe_c%0d: got we_n=%b d_oe=%b want 1 0", i, SRAM_WE_N, SRAM_D_oe); end
      step();
      if (i == 0) begin
        checks++; if (HEX_DATA !== 16'h0) begin errors++; $display("FAIL io_wr_hex_early: got %h want 0000", HEX_DATA); end
      end
    end
    checks++; if (HEX_DATA !== 16'h00A5) begin errors++; $display("FAIL io_wr_hex: got %h want 00a5", HEX_DATA); end

    // Same data to an SRAM address: strobe low for exactly two cycles.
    LD_MAR = 1'b1; Bus_in = 16'h0020;
    step();
    LD_MAR = 1'b0; Mem_WE = 1'b1;
    low_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) set_idle();
      if (SRAM_WE_N === 1'b0) low_cycles++;
      checks++; if (SRAM_WE_N !== !exp_low[i] || SRAM_D_oe !== exp_low[i])
        begin errors++; $display("FAIL sram_wr_strobe_c%0d: got we_n=%b d_oe=%b want %b %b", i, SRAM_WE_N, SRAM_D_oe, !exp_low[i], exp_low[i]); end
      checks++; if (SRAM_D_out !== 16'h00A5) begin errors++; $display("FAIL sram_wr_dout_c%0d: got %h want 00a5", i, SRAM_D_out); end
      step();
    end
    checks++; if (low_cycles != 2) begin errors++; $display("FAIL sram_wr_len: got %0d want 2", low_cycles); end
    checks++; if (HEX_DATA !== 16'h00A5) begin errors++; $display("FAIL sram_wr_hex: got %h want 00a5", HEX_DATA); end
  endtask

  task automatic test_hex_no_reload();
    do_reset();
    LD_MAR = 1'b1; Bus_in = IO;
    step();
    LD_MAR = 1'b0; LD_MDR = 1'b1; Bus_in = 16'h1357;
    step();
    LD_MDR = 1'b0; Mem_WE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin LD_MDR = 1'b1; Bus_in = 16'h2468; end
      if (i == 3) LD_MDR = 1'b0;
      step();
    end
    set_idle();
    step();
    checks++; if (HEX_DATA !== 16'h1357) begin errors++; $display("FAIL hex_no_reload: got %h want 1357", HEX_DATA); end
    checks++; if (MDR !== 16'h2468) begin errors++; $display("FAIL hex_mdr_update: got %h want 2468", MDR); end
  endtask

  task automatic test_errors();
    // Early capture in the first read cycle.
    do_reset();
    LD_MAR = 1'b1; Bus_in = 16'h0030;
    step();
    LD_MAR = 1'b0; Mem_OE = 1'b1; LD_MDR = 1'b1; SRAM_D_in = 16'hABCD;
    step();
    LD_MDR = 1'b0; SRAM_D_in = 16'h0000;
    step();
    set_idle();
    step();
    checks++; if (MDR !== 16'hABCD) begin errors++; $display("FAIL early_rd_mdr: got %h want abcd", MDR); end
    checks++; if (ACC_ERR !== 1'b1) begin errors++; $display("FAIL early_rd_err: got %b want 1", ACC_ERR); end
    repeat (3) step();
    checks++; if (ACC_ERR !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", ACC_ERR); end
    do_reset();
    checks++; if (ACC_ERR !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", ACC_ERR); end

    // Conflicting strobes from IDLE.
    LD_MAR = 1'b1; Bus_in = 16'h0060;
    step();
    LD_MAR = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b1;
    checks++; if (SRAM_OE_N !== 1'b1 || SRAM_WE_N !== 1'b1)
      begin errors++; $display("FAIL conflict_c0: got oe_n=%b we_n=%b want 1 1", SRAM_OE_N, SRAM_WE_N); end
    step();
    set_idle();
    checks++; if (SRAM_OE_N !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_D_oe !== 1'b0)
      begin errors++; $display("FAIL conflict_c1: got oe_n=%b we_n=%b d_oe=%b want 1 1 0", SRAM_OE_N, SRAM_WE_N, SRAM_D_oe); end
    checks++; if (ACC_ERR !== 1'b1) begin errors++; $display("FAIL conflict_err: got %b want 1", ACC_ERR); end
    step();

    // Conflict in the middle of a read aborts it.
    do_reset();
    Mem_OE = 1'b1;
    step();
    step();
    Mem_WE = 1'b1;
    step();
    set_idle();
    checks++; if (SRAM_OE_N !== 1'b1 || SRAM_WE_N !== 1'b1)
      begin errors++; $display("FAIL conflict_abort: got oe_n=%b we_n=%b want 1 1", SRAM_OE_N, SRAM_WE_N); end
    checks++; if (ACC_ERR !== 1'b1) begin errors++; $display("FAIL conflict_abort_err: got %b want 1", ACC_ERR); end

    // Address load during an access.
    do_reset();
    Mem_OE = 1'b1;
    step();
    step();
    LD_MAR = 1'b1; Bus_in = 16'h0040;
    step();
    set_idle();
    step();
    checks++; if (MAR !== 16'h0040) begin errors++; $display("FAIL busy_mar_load: got %h want 0040", MAR); end
    checks++; if (ACC_ERR !== 1'b1) begin errors++; $display("FAIL busy_mar_err: got %b want 1", ACC_ERR); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    LD_MAR = 1'b1; Bus_in = 16'h0050;
    step();
    LD_MAR = 1'b0; LD_MDR = 1'b1; Bus_in = 16'h7777;
    step();
    LD_MDR = 1'b0; Mem_WE = 1'b1;
    step();
    step();
    checks++; if (SRAM_WE_N !== 1'b0) begin errors++; $display("FAIL mid_wr_active: got %b want 0", SRAM_WE_N); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if (SRAM_WE_N !== 1'b1 || SRAM_D_oe !== 1'b0)
      begin errors++; $display("FAIL mid_wr_abort: got we_n=%b d_oe=%b want 1 0", SRAM_WE_N, SRAM_D_oe); end
    checks++; if (MAR !== 16'h0 || MDR !== 16'h0)
      begin errors++; $display("FAIL mid_wr_regs: got mar=%h mdr=%h want 0000 0000", MAR, MDR); end
    set_idle();
    step();
    step();
  endtask

  task automatic test_random();
    bit          wr, io, exp_low;
    logic [15:0] addr, data;
    int          len, ld_idx;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      wr     = 1'($urandom_range(0, 1));
      addr   = ($urandom_range(0, 3) == 0) ? IO : 16'($urandom);
      io     = (addr == IO);
      data   = 16'($urandom);
      len    = int'($urandom_range(1, 4));
      ld_idx = int'($urandom_range(0, len)) - 1;

      LD_MAR = 1'b1; Bus_in = addr;
      step();
      LD_MAR = 1'b0;
      m_mar = addr;
      if (wr) begin
        LD_MDR = 1'b1; Bus_in = data;
        step();
        LD_MDR = 1'b0;
        m_mdr = data;
      end

      for (int i = 0; i < len; i++) begin
        Mem_OE = !wr; Mem_WE = wr;
        LD_MDR = !wr && (i == ld_idx);
        SRAM_D_in = 16'($urandom); SW = 16'($urandom);
        exp_low = (i >= 1) && !io;
        checks++; if (SRAM_OE_N !== !(exp_low && !wr) || SRAM_WE_N !== !(exp_low && wr) || SRAM_D_oe !== (exp_low && wr))
          begin errors++; $display("FAIL rnd_strobe t%0d c%0d: got oe_n=%b we_n=%b d_oe=%b want %b %b %b", t, i,
            SRAM_OE_N, SRAM_WE_N, SRAM_D_oe, !(exp_low && !wr), !(exp_low && wr), exp_low && wr); end
        step();
        if (LD_MDR) begin
          m_mdr = io ? SW : SRAM_D_in;
          if (i == 0) m_err = 1'b1;
        end
        if (wr && io && i == 1) m_hex = m_mdr;
      end

      set_idle();
      exp_low = !io;
      checks++; if (SRAM_OE_N !== !(exp_low && !wr) || SRAM_WE_N !== !(exp_low && wr))
        begin errors++; $display("FAIL rnd_tail t%0d: got oe_n=%b we_n=%b want %b %b", t,
          SRAM_OE_N, SRAM_WE_N, !(exp_low && !wr), !(exp_low && wr)); end
      step();

      checks++; if (SRAM_OE_N !== 1'b1 || SRAM_WE_N !== 1'b1 || SRAM_D_oe !== 1'b0)
        begin errors++; $display("FAIL rnd_idle t%0d: got oe_n=%b we_n=%b d_oe=%b want 1 1 0", t, SRAM_OE_N, SRAM_WE_N, SRAM_D_oe); end
      checks++; if (MAR !== m_mar || SRAM_ADDR !== {4'h0, m_mar})
        begin errors++; $display("FAIL rnd_mar t%0d: got mar=%h addr=%h want %h", t, MAR, SRAM_ADDR, m_mar); end
      checks++; if (MDR !== m_mdr || SRAM_D_out !== m_mdr)
        begin errors++; $display("FAIL rnd_mdr t%0d: got mdr=%h dout=%h want %h", t, MDR, SRAM_D_out, m_mdr); end
      checks++; if (HEX_DATA !== m_hex) begin errors++; $display("FAIL rnd_hex t%0d: got %h want %h", t, HEX_DATA, m_hex); end
      checks++; if (ACC_ERR !== m_err) begin errors++; $display("FAIL rnd_err t%0d: got %b want %b", t, ACC_ERR, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_io_read();
    test_io_write();
    test_hex_no_reload();
    test_errors();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
